// File: rtl/adc_serial_sampler_pkg.sv
// Shared types and frame helpers for the AD7476-class serial ADC sampler.
// Holds the FSM state enum, default frame constants and the frame-length function.
package adc_serial_sampler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_DONE,
      ST_WAIT
   } adc_state_e;

   localparam int ADC_INPUT_BITS = 12;
   localparam int ADC_LEAD_BITS  = 4;
   localparam int ADC_FRAME_BITS = ADC_INPUT_BITS + ADC_LEAD_BITS;

   // clk cycles from cs_n fall to the end of the last sclk high phase
   function automatic int adc_frame_len(input int t_setup,
                                        input int clk_div,
                                        input int frame_bits);
      return t_setup + 2 * clk_div * frame_bits;
   endfunction

endpackage

// File: rtl/adc_sclk_div.sv
// SCLK phase generator for the serial ADC frame: low/high phases of CLK_DIV clk
// cycles each, capture strobe, bit-done pulse and bit counter over FRAME_BITS bits.
// Ports: clk, rst_n (sync, active-low), en_i (SHIFT state), start_i (SHIFT begins
// next cycle), sclk_o (registered, idles high), capture_o, bit_done_o, last_bit_o.
module adc_sclk_div
   import adc_serial_sampler_pkg::*;
#(
   parameter int CLK_DIV    = 2,
   parameter int FRAME_BITS = ADC_FRAME_BITS
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic start_i,
   output logic sclk_o,
   output logic capture_o,
   output logic bit_done_o,
   output logic last_bit_o
);

   localparam int DW = $clog2(CLK_DIV + 1);
   localparam int BW = $clog2(FRAME_BITS + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

   logic [DW-1:0] div_q, div_d;
   logic [BW-1:0] bit_q, bit_d;
   logic          phase_q, phase_d;
   logic          sclk_q, sclk_d;
   logic          tick;

   always_comb begin
      tick       = (div_q == DIV_LAST);
      capture_o  = en_i & ~phase_q & tick;
      bit_done_o = en_i & phase_q & tick;
      last_bit_o = (bit_q == BIT_LAST);
      div_d      = div_q;
      bit_d      = bit_q;
      phase_d    = phase_q;
      if (!en_i) begin
         div_d   = '0;
         bit_d   = '0;
         phase_d = 1'b0;
      end else if (tick) begin
         div_d   = '0;
         phase_d = ~phase_q;
         if (phase_q) bit_d = bit_q + 1'b1;
      end else begin
         div_d = div_q + 1'b1;
      end
      // sclk is registered: look one cycle ahead so it falls with SHIFT entry
      // and returns high after the final high phase without a glitch.
      if (start_i) begin
         sclk_d = 1'b0;
      end else if (en_i && !(bit_done_o && last_bit_o)) begin
         sclk_d = phase_d;
      end else begin
         sclk_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_q   <= '0;
         bit_q   <= '0;
         phase_q <= 1'b0;
         sclk_q  <= 1'b1;
      end else begin
         div_q   <= div_d;
         bit_q   <= bit_d;
         phase_q <= phase_d;
         sclk_q  <= sclk_d;
      end
   end

   assign sclk_o = sclk_q;

endmodule

// File: rtl/adc_serial_sampler.sv
// Periodic master for a 12-bit AD7476-class serial ADC: drives cs_n/sclk, shifts
// in adc_sdata MSB first, presents sample with an adc_complete strobe and flags
// nonzero leading bits on frame_err. Optional ADC_SAMPLER_AVG_EN averages
// 2^AVG_LOG2 frames per published sample.
// Ports: clk, rst_n (sync, active-low), en, adc_sdata -> adc_cs_n, adc_sclk,
// sample[INPUT_BIT_WIDTH], adc_complete, frame_err.
module adc_serial_sampler
   import adc_serial_sampler_pkg::*;
#(
   parameter int INPUT_BIT_WIDTH  = ADC_INPUT_BITS,
   parameter int FRAME_BITS       = ADC_FRAME_BITS,
   parameter int CLK_DIV          = 2,
   parameter int T_SETUP          = 2,
   parameter int T_QUIET          = 4,
   parameter int PERIOD_BIT_WIDTH = 21,
   parameter int SAMPLE_PERIOD    = 1000,
   parameter int COMPLETE_HOLD    = 4,
   parameter int AVG_LOG2         = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   input  logic                       adc_sdata,
   output logic                       adc_cs_n,
   output logic                       adc_sclk,
   output logic [INPUT_BIT_WIDTH-1:0] sample,
   output logic                       adc_complete,
   output logic                       frame_err
);

   localparam int PW = PERIOD_BIT_WIDTH;
   localparam int FRAME_LEN = adc_frame_len(T_SETUP, CLK_DIV, FRAME_BITS);
   localparam int MIN_PERIOD = FRAME_LEN + T_QUIET;
   // short periods stretch to back-to-back operation
   localparam int EFF_PERIOD =
      (SAMPLE_PERIOD > MIN_PERIOD) ? SAMPLE_PERIOD : MIN_PERIOD;
   localparam logic [PW-1:0] PER_LAST = PW'(EFF_PERIOD - 1);
   localparam logic [PW-1:0] PER_MAX  = '1;
   localparam int TW = $clog2(T_SETUP + 1);
   localparam logic [TW-1:0] SETUP_LAST = TW'(T_SETUP - 1);
   localparam int HW = $clog2(COMPLETE_HOLD + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(COMPLETE_HOLD - 1);

   adc_state_e                 state_q;
   logic                       cs_n_q;
   logic [INPUT_BIT_WIDTH-1:0] sample_q;
   logic                       cmpl_q;
   logic [HW-1:0]              hold_q;
   logic                       ferr_q;
   logic [PW-1:0]              per_q;
   logic [TW-1:0]              tcnt_q;
   logic [FRAME_BITS-1:0]      shreg_q;

   logic shift_en;
   logic setup_end;
   logic capture;
   logic bit_done;
   logic last_bit;
   logic lead_nz;

`ifdef ADC_SAMPLER_AVG_EN
   localparam int ACC_W = INPUT_BIT_WIDTH + AVG_LOG2;
   localparam logic [AVG_LOG2-1:0] GRP_LAST = '1;
   logic [ACC_W-1:0]    acc_q;
   logic [ACC_W-1:0]    acc_sum;
   logic [AVG_LOG2-1:0] grp_q;

   always_comb begin
      acc_sum = acc_q + ACC_W'(shreg_q[INPUT_BIT_WIDTH-1:0]);
   end
`else
   // averaging depth only matters to the averaging build
   localparam int unused_avg_log2 = AVG_LOG2;
`endif

   assign shift_en  = (state_q == ST_SHIFT);
   assign setup_end = (state_q == ST_SETUP) && (tcnt_q == SETUP_LAST);
   assign lead_nz   = (shreg_q[FRAME_BITS-1:INPUT_BIT_WIDTH] != '0);

   adc_sclk_div #(
      .CLK_DIV   (CLK_DIV),
      .FRAME_BITS(FRAME_BITS)
   ) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (shift_en),
      .start_i   (setup_end),
      .sclk_o    (adc_sclk),
      .capture_o (capture),
      .bit_done_o(bit_done),
      .last_bit_o(last_bit)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cs_n_q   <= 1'b1;
         sample_q <= '0;
         cmpl_q   <= 1'b0;
         hold_q   <= '0;
         ferr_q   <= 1'b0;
         per_q    <= '0;
         tcnt_q   <= '0;
         shreg_q  <= '0;
`ifdef ADC_SAMPLER_AVG_EN
         acc_q    <= '0;
         grp_q    <= '0;
`endif
      end else begin
         ferr_q <= 1'b0;
         if (per_q != PER_MAX) per_q <= per_q + 1'b1;
         if (cmpl_q) begin
            if (hold_q == '0) cmpl_q <= 1'b0;
            else              hold_q <= hold_q - 1'b1;
         end
         if (capture) shreg_q <= {shreg_q[FRAME_BITS-2:0], adc_sdata};
         unique case (state_q)
            ST_IDLE: begin
               if (en) begin
                  state_q <= ST_SETUP;
                  cs_n_q  <= 1'b0;
                  per_q   <= '0;
                  tcnt_q  <= '0;
               end
            end
            ST_SETUP: begin
               if (setup_end) state_q <= ST_SHIFT;
               else           tcnt_q  <= tcnt_q + 1'b1;
            end
            ST_SHIFT: begin
               if (bit_done && last_bit) begin
                  state_q <= ST_DONE;
                  cs_n_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_WAIT;
               ferr_q  <= lead_nz;
`ifdef ADC_SAMPLER_AVG_EN
               if (grp_q == GRP_LAST) begin
                  sample_q <= acc_sum[ACC_W-1:AVG_LOG2];
                  cmpl_q   <= 1'b1;
                  hold_q   <= HOLD_LAST;
                  acc_q    <= '0;
                  grp_q    <= '0;
               end else begin
                  acc_q <= acc_sum;
                  grp_q <= grp_q + 1'b1;
               end
`else
               sample_q <= shreg_q[INPUT_BIT_WIDTH-1:0];
               cmpl_q   <= 1'b1;
               hold_q   <= HOLD_LAST;
`endif
            end
            ST_WAIT: begin
               if (!en) begin
                  state_q <= ST_IDLE;
`ifdef ADC_SAMPLER_AVG_EN
                  acc_q   <= '0;
                  grp_q   <= '0;
`endif
               end else if (per_q >= PER_LAST) begin
                  state_q <= ST_SETUP;
                  cs_n_q  <= 1'b0;
                  per_q   <= '0;
                  tcnt_q  <= '0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign adc_cs_n     = cs_n_q;
   assign sample       = sample_q;
   assign adc_complete = cmpl_q;
   assign frame_err    = ferr_q;

endmodule
